lru_tree: RTL and testbench
===========================

LRU_TREE -- requirements
Module: lru_tree

Interface
REQ-001 SHALL have parameter ENTRIES, default 256: number of sets tracked.
REQ-002 SHALL have parameter INDEX_BITS, default 8: set index width; ENTRIES <= 2**INDEX_BITS.
REQ-003 SHALL have parameter WAYS, default 4: associativity; power of two, >= 2; WAY_BITS = clog2(WAYS).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port line_selector  input  INDEX_BITS: set index for the read port.
REQ-007 SHALL have port valid_ways  input  WAYS: per-way valid bits of the set addressed by line_selector.
REQ-008 SHALL have port lru_way  output  WAY_BITS: victim way for line_selector.
REQ-009 SHALL have port lru_update  input  1: record an access this cycle.
REQ-010 SHALL have port update_index  input  INDEX_BITS: set index being updated.
REQ-011 SHALL have port referenced_way  input  WAY_BITS: way accessed in update_index.
REQ-012 SHALL have port flush_req  input  1: request to clear all LRU state.
REQ-013 SHALL have port busy  output  1: flush sweep in progress.

Function
REQ-014 SHALL store WAYS-1 tree-PLRU bits per set; node 0 is root, node i has children 2i+1 (lower ways) and 2i+2 (upper ways); leaves map to ways in ascending order.
REQ-015 SHALL interpret a node bit of 0 as "victim in lower-way subtree" and 1 as "victim in upper-way subtree".
REQ-016 SHALL produce lru_way combinationally from the stored bits of line_selector and valid_ways, zero cycles latency.
REQ-017 SHALL output the lowest-numbered way with valid_ways bit 0 if any exist; otherwise the leaf reached by walking the tree from the root.
REQ-018 SHALL, on lru_update while not busy, set every node on the path to referenced_way to point away from it (0 if the path goes upper, 1 if lower); off-path nodes unchanged.
REQ-019 SHALL make an update visible on lru_way from the cycle after it; a same-cycle read of the same set returns pre-update state.
REQ-020 SHALL ignore update_index values >= ENTRIES (no state change).
REQ-021 SHALL implement a two-state FSM IDLE/FLUSH; busy = 1 exactly in FLUSH.
REQ-022 SHALL, on flush_req in IDLE, enter FLUSH next cycle with sweep counter 0; lru_update in the accepting cycle is dropped.
REQ-023 SHALL in FLUSH clear all bits of set [counter] each cycle, increment counter, and return to IDLE after clearing set ENTRIES-1 (busy high exactly ENTRIES cycles).
REQ-024 SHALL ignore lru_update and flush_req while in FLUSH; lru_way remains driven from current (partially cleared) state.
REQ-025 SHALL give the updated set's result equal to (WAYS=2) stored bit = ~referenced_way, identical to the existing 2-way block.

Reset
REQ-026 SHALL, with rst high at a clock edge, clear all PLRU bits, sweep counter to 0, FSM to IDLE, busy to 0; rst has priority over all inputs.
REQ-027 SHALL after reset give lru_way = 0 for every set with all valid_ways = 1.
REQ-028 SHALL, on rst asserted mid-flush, abort the sweep and return to IDLE with all state cleared.

Verification
REQ-029 SHALL cover: WAYS=4, reset, valid_ways=4'hF, any set -> lru_way=0, busy=0.
REQ-030 SHALL cover: WAYS=4, set 5, update way 0 -> next cycle lru_way=2; then update way 2 -> next cycle lru_way=1; set 6 still 0.
REQ-031 SHALL cover: valid_ways=4'b1011 with any tree state -> lru_way=2; valid_ways=4'b0000 -> lru_way=0.
REQ-032 SHALL cover: ENTRIES=8, dirty several sets, flush_req for 1 cycle -> busy high exactly 8 cycles, updates during busy ignored, all sets read lru_way=0 afterwards.
REQ-033 SHALL cover: same-cycle update and read of set 3 -> pre-update lru_way that cycle, post-update value next cycle.
REQ-034 SHALL cover: rst asserted in cycle 3 of a flush -> busy=0 next cycle, all sets lru_way=0, new flush_req accepted afterwards.

Source files
------------

// File: rtl/lru_tree.sv
// Tree pseudo-LRU victim selection for a set-associative cache.
// Holds WAYS-1 PLRU bits per set, with a sequential flush sweep.
module lru_tree #(
    parameter int ENTRIES    = 256,
    parameter int INDEX_BITS = 8,
    parameter int WAYS       = 4,
    parameter int WAY_BITS   = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] line_selector,
    input  logic [WAYS-1:0]       valid_ways,
    output logic [WAY_BITS-1:0]   lru_way,
    input  logic                  lru_update,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic [WAY_BITS-1:0]   referenced_way,
    input  logic                  flush_req,
    output logic                  busy
);

    localparam int NODES = WAYS - 1;
    localparam logic [INDEX_BITS:0] ENT = (INDEX_BITS+1)'(ENTRIES);
    localparam logic [INDEX_BITS-1:0] LAST = INDEX_BITS'(ENTRIES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NODES-1:0]      plru [ENTRIES];
    logic [INDEX_BITS-1:0] sweep_cnt;

    logic                  rd_ok;
    logic                  upd_ok;
    logic [NODES-1:0]      rd_bits;
    logic [NODES-1:0]      upd_cur;
    logic [NODES-1:0]      upd_bits;
    logic [WAY_BITS-1:0]   tree_way;
    logic [WAY_BITS-1:0]   inv_way;
    logic                  inv_found;
    logic                  upd_en;
    logic                  flush_go;

    assign rd_ok  = {1'b0, line_selector} < ENT;
    assign upd_ok = {1'b0, update_index} < ENT;
    assign rd_bits = rd_ok ? plru[line_selector] : '0;
    assign upd_cur = upd_ok ? plru[update_index] : '0;

    assign busy     = (state == FLUSH);
    assign flush_go = (state == IDLE) && flush_req;
    assign upd_en   = (state == IDLE) && !flush_req
                      && lru_update && upd_ok;

    // Walk the tree from the root following the stored node bits.
    always_comb begin
        int  node;
        logic b;
        tree_way = '0;
        node     = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b = 1'b0;
            for (int n = 0; n < NODES; n++) begin
                if (node == n) b = rd_bits[n];
            end
            tree_way[WAY_BITS-1-l] = b;
            node = 2 * node + (b ? 2 : 1);
        end
    end

    // Lowest-numbered invalid way takes precedence over the tree.
    always_comb begin
        inv_way   = '0;
        inv_found = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_ways[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
    end

    assign lru_way = inv_found ? inv_way : tree_way;

    // Point every node on the referenced path away from it.
    always_comb begin
        int   node;
        logic dir;
        upd_bits = upd_cur;
        node     = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            dir = referenced_way[WAY_BITS-1-l];
            for (int n = 0; n < NODES; n++) begin
                if (node == n) upd_bits[n] = ~dir;
            end
            node = 2 * node + (dir ? 2 : 1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state: sweep runs until the last set is cleared.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (flush_req) state_nxt = FLUSH;
            FLUSH:   if (sweep_cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep counter restarts on each accepted flush.
    always_ff @(posedge clk) begin
        if (rst)
            sweep_cnt <= '0;
        else if (flush_go)
            sweep_cnt <= '0;
        else if (state == FLUSH)
            sweep_cnt <= (sweep_cnt == LAST) ? '0 : sweep_cnt + 1'b1;
    end

    // PLRU storage: reset, flush clear, or access update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) plru[i] <= '0;
        end else if (state == FLUSH) begin
            plru[sweep_cnt] <= '0;
        end else if (upd_en) begin
            plru[update_index] <= upd_bits;
        end
    end

endmodule

// File: tb/tb_lru_tree.sv
// Directed bench for lru_tree, 8 sets x 4 ways.
// Expected victims are hand-derived from the tree-PLRU rules.
module tb_lru_tree;

    localparam int ENTRIES    = 8;
    localparam int INDEX_BITS = 3;
    localparam int WAYS       = 4;
    localparam int WAY_BITS   = 2;

    logic                  clk;
    logic                  rst;
    logic [INDEX_BITS-1:0] line_selector;
    logic [WAYS-1:0]       valid_ways;
    logic [WAY_BITS-1:0]   lru_way;
    logic                  lru_update;
    logic [INDEX_BITS-1:0] update_index;
    logic [WAY_BITS-1:0]   referenced_way;
    logic                  flush_req;
    logic                  busy;

    int errors;
    int checks;

    lru_tree #(
        .ENTRIES   (ENTRIES),
        .INDEX_BITS(INDEX_BITS),
        .WAYS      (WAYS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .line_selector (line_selector),
        .valid_ways    (valid_ways),
        .lru_way       (lru_way),
        .lru_update    (lru_update),
        .update_index  (update_index),
        .referenced_way(referenced_way),
        .flush_req     (flush_req),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_update(input int idx, input int way);
        @(negedge clk);
        lru_update     = 1'b1;
        update_index   = INDEX_BITS'(idx);
        referenced_way = WAY_BITS'(way);
        @(negedge clk);
        lru_update     = 1'b0;
    endtask

    task automatic test_reset();
        logic [WAY_BITS-1:0] w;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        valid_ways = 4'hF;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        for (int s = 0; s < ENTRIES; s++) begin
            line_selector = INDEX_BITS'(s);
            #1;
            w = lru_way;
            checks++;
            if (w !== 2'd0) begin
                errors++;
                $display("FAIL reset_set%0d got=%0d exp=0", s, w);
            end
        end
    endtask

    task automatic test_update();
        valid_ways = 4'hF;
        do_update(5, 0);
        line_selector = 3'd5;
        #1;
        checks++;
        if (lru_way !== 2'd2) begin
            errors++;
            $display("FAIL upd_way0 got=%0d exp=2", lru_way);
        end
        do_update(5, 2);
        line_selector = 3'd5;
        #1;
        checks++;
        if (lru_way !== 2'd1) begin
            errors++;
            $display("FAIL upd_way2 got=%0d exp=1", lru_way);
        end
        line_selector = 3'd6;
        #1;
        checks++;
        if (lru_way !== 2'd0) begin
            errors++;
            $display("FAIL upd_set6 got=%0d exp=0", lru_way);
        end
    endtask

    task automatic test_valid();
        line_selector = 3'd5;
        valid_ways = 4'b1011;
        #1;
        checks++;
        if (lru_way !== 2'd2) begin
            errors++;
            $display("FAIL valid_1011 got=%0d exp=2", lru_way);
        end
        valid_ways = 4'b0000;
        #1;
        checks++;
        if (lru_way !== 2'd0) begin
            errors++;
            $display("FAIL valid_0000 got=%0d exp=0", lru_way);
        end
        valid_ways = 4'b0111;
        #1;
        checks++;
        if (lru_way !== 2'd3) begin
            errors++;
            $display("FAIL valid_0111 got=%0d exp=3", lru_way);
        end
        valid_ways = 4'hF;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        lru_update     = 1'b1;
        update_index   = 3'd1;
        referenced_way = 2'd3;
        @(negedge clk);
        referenced_way = 2'd1;
        @(negedge clk);
        lru_update     = 1'b0;
        line_selector  = 3'd1;
        #1;
        checks++;
        if (lru_way !== 2'd2) begin
            errors++;
            $display("FAIL b2b_set1 got=%0d exp=2", lru_way);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        line_selector  = 3'd3;
        lru_update     = 1'b1;
        update_index   = 3'd3;
        referenced_way = 2'd0;
        #1;
        checks++;
        if (lru_way !== 2'd0) begin
            errors++;
            $display("FAIL same_pre got=%0d exp=0", lru_way);
        end
        @(negedge clk);
        lru_update = 1'b0;
        #1;
        checks++;
        if (lru_way !== 2'd2) begin
            errors++;
            $display("FAIL same_post got=%0d exp=2", lru_way);
        end
    endtask

    task automatic test_flush();
        int busy_cycles;
        int guard;
        logic seen;
        do_update(2, 3);
        do_update(7, 0);
        @(negedge clk);
        flush_req      = 1'b1;
        lru_update     = 1'b1;
        update_index   = 3'd4;
        referenced_way = 2'd0;
        @(negedge clk);
        flush_req   = 1'b0;
        busy_cycles = 0;
        seen        = 1'b0;
        guard       = 0;
        while (guard < 20) begin
            #1;
            if (busy) begin
                busy_cycles++;
                seen = 1'b1;
                lru_update   = 1'b1;
                update_index = 3'd0;
                referenced_way = 2'd1;
                flush_req    = (busy_cycles == 3);
            end else if (seen) begin
                break;
            end
            @(negedge clk);
            guard++;
        end
        lru_update = 1'b0;
        flush_req  = 1'b0;
        checks++;
        if (busy_cycles != 8) begin
            errors++;
            $display("FAIL flush_len got=%0d exp=8", busy_cycles);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got=%b exp=0", busy);
        end
        for (int s = 0; s < ENTRIES; s++) begin
            line_selector = INDEX_BITS'(s);
            #1;
            checks++;
            if (lru_way !== 2'd0) begin
                errors++;
                $display("FAIL flush_set%0d got=%0d exp=0", s, lru_way);
            end
        end
    endtask

    task automatic test_rst_mid_flush();
        int n;
        int guard;
        do_update(2, 0);
        do_update(6, 1);
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 10) begin
            #1;
            if (busy) n++;
            if (n < 3) @(negedge clk);
            guard++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL midrst_busy got=%0d exp=3", n);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle got=%b exp=0", busy);
        end
        for (int s = 0; s < ENTRIES; s++) begin
            line_selector = INDEX_BITS'(s);
            #1;
            checks++;
            if (lru_way !== 2'd0) begin
                errors++;
                $display("FAIL midrst_set%0d got=%0d exp=0", s, lru_way);
            end
        end
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reflush_busy got=%b exp=1", busy);
        end
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reflush_done got=%b exp=0", busy);
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        line_selector  = '0;
        valid_ways     = 4'hF;
        lru_update     = 1'b0;
        update_index   = '0;
        referenced_way = '0;
        flush_req      = 1'b0;
        test_reset();
        test_update();
        test_valid();
        test_back_to_back();
        test_same_cycle();
        test_flush();
        test_rst_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
